// File: rtl/spi_dev_regs_pkg.sv
// rtl/spi_dev_regs_pkg.sv - shared definitions for the SPI/Wishbone register block
// Purpose: FSM state encoding, default SPI command codes, register count and
//          pointer width, plus a byte-select helper for the read path.
package spi_dev_regs_pkg;

  localparam int REG_COUNT = 8;
  localparam int PTR_W     = 3;

  localparam logic [7:0] CMD_WR_DEFAULT = 8'hF2;
  localparam logic [7:0] CMD_RD_DEFAULT = 8'hF3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_SKIP
  } state_t;

  // Little-endian byte lane select of a 32-bit word.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_dev_regs.sv
// rtl/spi_dev_regs.sv - eight 32-bit registers shared by an SPI byte stream and a Wishbone slave
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pw_wdata/pw_wcmd/pw_wstb      incoming SPI bytes, pw_wcmd marks the command byte
//   pw_end                        chip-select release pulse
//   pw_req/pw_gnt                 response arbiter request/grant
//   pw_rdata/pw_rstb              response byte and its consume strobe
//   wb_addr..wb_ack               CPU Wishbone slave (single-cycle ack)
//   irq                           doorbell; live only when SPI_DEV_REGS_IRQ_EN is defined
module spi_dev_regs
  import spi_dev_regs_pkg::*;
#(
  parameter logic [7:0] CMD_WR = CMD_WR_DEFAULT,
  parameter logic [7:0] CMD_RD = CMD_RD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pw_wdata,
  input  logic        pw_wcmd,
  input  logic        pw_wstb,
  input  logic        pw_end,
  output logic        pw_req,
  input  logic        pw_gnt,
  output logic [7:0]  pw_rdata,
  input  logic        pw_rstb,
  input  logic [2:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic        irq
);

  logic [31:0]      regs [REG_COUNT];
  state_t           state, state_nx;
  logic             is_rd;
  logic [PTR_W-1:0] ptr, ptr_inc;
  logic [1:0]       byte_idx;
  logic [23:0]      wbuf;
  logic             commit_pend;
  logic [PTR_W-1:0] commit_ptr;
  logic [31:0]      commit_word;
  logic [31:0]      snap;
  logic             req_q;
  logic             ack_q;
  logic             cmd_byte, data_byte, rd_adv, wb_wr, wb_rd;

  assign cmd_byte  = pw_wstb & pw_wcmd;
  assign data_byte = pw_wstb & ~pw_wcmd;
  assign rd_adv    = (state == ST_RDATA) & pw_rstb & pw_gnt;
  assign ptr_inc   = ptr + 1'b1;
  assign wb_wr     = ack_q & wb_cyc & wb_we;
  assign wb_rd     = ack_q & wb_cyc & ~wb_we;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (pw_end) begin
      state_nx = ST_IDLE;
    end else if (cmd_byte) begin
      state_nx = (pw_wdata == CMD_WR || pw_wdata == CMD_RD) ? ST_ADDR : ST_SKIP;
    end else if (data_byte && state == ST_ADDR) begin
      state_nx = is_rd ? ST_RDATA : ST_WDATA;
    end
  end

  // Byte assembly, pointer and read snapshot. The write path shifts bytes in
  // from the top so after three bytes wbuf holds {b2,b1,b0}; the fourth byte
  // completes the word, which lands in the register file one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_rd       <= 1'b0;
      ptr         <= '0;
      byte_idx    <= '0;
      wbuf        <= '0;
      commit_pend <= 1'b0;
      commit_ptr  <= '0;
      commit_word <= '0;
      snap        <= '0;
      req_q       <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      req_q       <= (state == ST_RDATA) && (state_nx == ST_RDATA);
      if (cmd_byte) is_rd <= (pw_wdata == CMD_RD);
      if (pw_end || cmd_byte) begin
        byte_idx <= '0;
      end else if (data_byte && state == ST_ADDR) begin
        ptr      <= pw_wdata[PTR_W-1:0];
        byte_idx <= '0;
        if (is_rd) snap <= regs[pw_wdata[PTR_W-1:0]];
      end else if (data_byte && state == ST_WDATA) begin
        if (byte_idx == 2'd3) begin
          commit_pend <= 1'b1;
          commit_word <= {pw_wdata, wbuf};
          commit_ptr  <= ptr;
          ptr         <= ptr_inc;
          byte_idx    <= '0;
        end else begin
          wbuf     <= {pw_wdata, wbuf[23:8]};
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (rd_adv) begin
        if (byte_idx == 2'd3) begin
          byte_idx <= '0;
          ptr      <= ptr_inc;
          snap     <= regs[ptr_inc];
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  // SPI commit is applied last so it wins a same-register collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      if (wb_wr)       regs[wb_addr]    <= wb_wdata;
      if (commit_pend) regs[commit_ptr] <= commit_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= wb_cyc & ~ack_q;
  end

  assign wb_ack   = ack_q;
  assign wb_rdata = (ack_q && !wb_we) ? regs[wb_addr] : '0;
  assign pw_req   = req_q;
  assign pw_rdata = (state == ST_RDATA) ? byte_sel(snap, byte_idx) : '0;

`ifdef SPI_DEV_REGS_IRQ_EN
  logic [REG_COUNT-1:0] dirty;

  // Set after clear so a commit racing the clearing read keeps the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty <= '0;
    end else begin
      if (wb_rd)       dirty[wb_addr]    <= 1'b0;
      if (commit_pend) dirty[commit_ptr] <= 1'b1;
    end
  end

  assign irq = |dirty;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dev_regs.sv
// tb/tb_spi_dev_regs.sv - directed, table-driven bench for spi_dev_regs
module tb_spi_dev_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pw_wdata = '0;
  logic        pw_wcmd = 1'b0, pw_wstb = 1'b0, pw_end = 1'b0;
  logic        pw_req, pw_gnt = 1'b0, pw_rstb = 1'b0;
  logic [7:0]  pw_rdata;
  logic [2:0]  wb_addr = '0;
  logic [31:0] wb_wdata = '0, wb_rdata;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_ack, irq;

`ifdef SPI_DEV_REGS_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  int n_pass = 0;
  int n_total = 0;

  spi_dev_regs dut (
    .clk(clk), .rst(rst),
    .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb), .pw_end(pw_end),
    .pw_req(pw_req), .pw_gnt(pw_gnt), .pw_rdata(pw_rdata), .pw_rstb(pw_rstb),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        spi_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] expect_word;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic spi_tx(input logic [7:0] d, input logic c);
    pw_wdata = d; pw_wcmd = c; pw_wstb = 1'b1;
    tick();
    pw_wstb = 1'b0; pw_wcmd = 1'b0;
  endtask

  task automatic spi_end();
    pw_end = 1'b1;
    tick();
    pw_end = 1'b0;
    tick();
  endtask

  task automatic spi_write_word(input logic [2:0] a, input logic [31:0] w);
    spi_tx(8'hF2, 1'b1);
    spi_tx({5'd0, a}, 1'b0);
    for (int i = 0; i < 4; i++) spi_tx(w[8*i +: 8], 1'b0);
    spi_end();
  endtask

  task automatic spi_read_word(input logic [2:0] a, output logic [31:0] w);
    spi_tx(8'hF3, 1'b1);
    spi_tx({5'd0, a}, 1'b0);
    pw_gnt = 1'b1;
    tick();
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = pw_rdata;
      pw_rstb = 1'b1;
      tick();
      pw_rstb = 1'b0;
    end
    pw_gnt = 1'b0;
    spi_end();
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [31:0] wd,
                         output logic [31:0] rd);
    logic got;
    wb_addr = a; wb_we = we; wb_wdata = wd; wb_cyc = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      tick();
      if (wb_ack) got = 1'b1;
    end
    if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
    rd = wb_rdata;
    tick();
    wb_cyc = 1'b0; wb_we = 1'b0;
    tick();
  endtask

  vec_t vecs[4];

  initial begin
    logic [31:0] rd;

    vecs[0] = '{1'b1, 3'd5, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    vecs[1] = '{1'b1, 3'd6, 32'h0000_00FF, 32'h0000_00FF};
    vecs[2] = '{1'b0, 3'd4, 32'h1234_5678, 32'h1234_5678};
    vecs[3] = '{1'b0, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_pw_req", {31'd0, pw_req}, 32'd0);
    check("rst_pw_rdata", {24'd0, pw_rdata}, 32'd0);
    check("rst_wb_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_wb_rdata", wb_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    wb_xfer(1'b0, 3'd3, 32'd0, rd);
    check("rst_reg3", rd, 32'd0);

    // Basic write then read-back over Wishbone.
    spi_tx(8'hF2, 1'b1); spi_tx(8'h03, 1'b0);
    spi_tx(8'h44, 1'b0); spi_tx(8'h33, 1'b0); spi_tx(8'h22, 1'b0); spi_tx(8'h11, 1'b0);
    spi_end();
    wb_xfer(1'b0, 3'd3, 32'd0, rd);
    check("wr_readback_reg3", rd, 32'h1122_3344);

    // Pointer wrap 7->0 and a trailing partial word.
    spi_tx(8'hF2, 1'b1); spi_tx(8'h07, 1'b0);
    for (int i = 1; i <= 8; i++) spi_tx(8'(i), 1'b0);
    spi_tx(8'hAA, 1'b0);
    spi_end();
    wb_xfer(1'b0, 3'd7, 32'd0, rd);
    check("wrap_reg7", rd, 32'h0403_0201);
    wb_xfer(1'b0, 3'd0, 32'd0, rd);
    check("wrap_reg0", rd, 32'h0807_0605);
    wb_xfer(1'b0, 3'd1, 32'd0, rd);
    check("partial_reg1", rd, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].spi_wr) begin
        spi_write_word(vecs[i].addr, vecs[i].data);
        wb_xfer(1'b0, vecs[i].addr, 32'd0, rd);
      end else begin
        wb_xfer(1'b1, vecs[i].addr, vecs[i].data, rd);
        spi_read_word(vecs[i].addr, rd);
      end
      check($sformatf("vec%0d", i), rd, vecs[i].expect_word);
    end

    // Granted read of reg2 with a concurrent Wishbone overwrite mid-word.
    wb_xfer(1'b1, 3'd2, 32'hDEAD_BEEF, rd);
    spi_tx(8'hF3, 1'b1); spi_tx(8'h02, 1'b0);
    tick();
    check("rd_req_nogrant_byte0", {24'd0, pw_rdata}, 32'h0000_00EF);
    pw_rstb = 1'b1; tick(); pw_rstb = 1'b0;
    check("rstb_without_gnt", {24'd0, pw_rdata}, 32'h0000_00EF);
    pw_gnt = 1'b1;
    check("rd_pw_req", {31'd0, pw_req}, 32'd1);
    pw_rstb = 1'b1; tick(); pw_rstb = 1'b0;
    check("rd_byte1", {24'd0, pw_rdata}, 32'h0000_00BE);
    pw_rstb = 1'b1; tick(); pw_rstb = 1'b0;
    check("rd_byte2", {24'd0, pw_rdata}, 32'h0000_00AD);
    wb_xfer(1'b1, 3'd2, 32'd0, rd);
    check("tear_byte2", {24'd0, pw_rdata}, 32'h0000_00AD);
    pw_rstb = 1'b1; tick(); pw_rstb = 1'b0;
    check("tear_byte3", {24'd0, pw_rdata}, 32'h0000_00DE);
    pw_rstb = 1'b1; tick(); pw_rstb = 1'b0;
    check("rd_next_reg3_byte0", {24'd0, pw_rdata}, 32'h0000_0044);
    pw_gnt = 1'b0;
    spi_end();
    check("req_drop_after_end", {31'd0, pw_req}, 32'd0);

    // SPI commit and Wishbone write to reg4 in the same cycle.
    spi_tx(8'hF2, 1'b1); spi_tx(8'h04, 1'b0);
    spi_tx(8'h05, 1'b0); spi_tx(8'h00, 1'b0); spi_tx(8'h00, 1'b0);
    pw_wdata = 8'h00; pw_wstb = 1'b1;
    wb_addr = 3'd4; wb_we = 1'b1; wb_wdata = 32'h9; wb_cyc = 1'b1;
    tick();
    pw_wstb = 1'b0;
    check("collide_ack", {31'd0, wb_ack}, 32'd1);
    tick();
    wb_cyc = 1'b0; wb_we = 1'b0;
    tick();
    spi_end();
    wb_xfer(1'b0, 3'd4, 32'd0, rd);
    check("collide_reg4", rd, 32'h5);

    // Unknown command: following bytes are skipped.
    spi_tx(8'h55, 1'b1);
    for (int i = 0; i < 4; i++) spi_tx(8'hEE, 1'b0);
    spi_end();
    wb_xfer(1'b0, 3'd0, 32'd0, rd);
    check("skip_reg0", rd, 32'h0807_0605);

    // A new command byte mid-word restarts and drops the partial word.
    spi_tx(8'hF2, 1'b1); spi_tx(8'h05, 1'b0); spi_tx(8'hAA, 1'b0); spi_tx(8'hBB, 1'b0);
    spi_tx(8'hF2, 1'b1); spi_tx(8'h06, 1'b0);
    for (int i = 1; i <= 4; i++) spi_tx(8'(i), 1'b0);
    spi_end();
    wb_xfer(1'b0, 3'd5, 32'd0, rd);
    check("restart_reg5", rd, 32'hA5A5_0F0F);
    wb_xfer(1'b0, 3'd6, 32'd0, rd);
    check("restart_reg6", rd, 32'h0403_0201);

    // Doorbell.
    for (int a = 0; a < 8; a++) wb_xfer(1'b0, 3'(a), 32'd0, rd);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    spi_write_word(3'd1, 32'hCAFE_0001);
    check("irq_after_spi_wr", {31'd0, irq}, {31'd0, IRQ_EXP});
    wb_xfer(1'b0, 3'd1, 32'd0, rd);
    check("irq_reg1_data", rd, 32'hCAFE_0001);
    check("irq_after_wb_rd", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
